forwarding_unit: RTL and testbench
==================================

Name: forwarding_unit

Overview:
- Hazard-detection and forwarding-control block for the 5-stage pipeline.
- Produces the 2-bit selection codes consumed by the ALU-operand forwarding muxes; it is the driving end of that interface.
- Internally tracks destination-register metadata of in-flight instructions (EX, MEM, WB slots).
- Generates load-use stalls and EX-bubble insertion.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 16, width of the stall/forward statistics counters (only used with FWD_STATS_EN).

Ports:
- clk  in  1  pipeline clock
- arst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_ADDR_W  source register 1 of ID instruction
- id_rs2  in  REG_ADDR_W  source register 2
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_rd  in  REG_ADDR_W  destination register
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- flush  in  1  taken branch; squash ID instruction
- fwd_sel_a  out  2  operand-A mux select for instruction in EX
- fwd_sel_b  out  2  operand-B mux select for instruction in EX
- stall  out  1  hold PC and IF/ID; combinational
- stall_count  out  CNT_W  load-use stall cycles (FWD_STATS_EN)
- fwd_count  out  CNT_W  cycles with a non-zero select (FWD_STATS_EN)

Behaviour:
- Select encoding, fixed: 2'b00 = register-file value; 2'b01 = EX/MEM ALU result; 2'b10 = MEM/WB write-back value. 2'b11 is never driven.
- Metadata slots: ex, mem and wb, each holding {valid, rd, reg_write, mem_read}.
- Every posedge: wb<=mem, mem<=ex. ex<=ID metadata, or a bubble (valid=0) when stall or flush is asserted, or when id_valid=0.
- Reset (arst_n low, asynchronous): all slot valids=0, fwd_sel_a=fwd_sel_b=2'b00, counters=0. stall is 0 while in reset.
- Hazard match: "match(slot, rs)" = slot.valid & slot.reg_write & (slot.rd != 0) & (slot.rd == rs).
- Load-use stall: stall = id_valid & ~flush & ex.mem_read & (match(ex,id_rs1)&id_uses_rs1 | match(ex,id_rs2)&id_uses_rs2).
- Select computation for each operand X (rs1→a, rs2→b), computed in ID and registered at the edge where the instruction enters EX, so it is valid for the full EX cycle:
  - uses_X & match(ex,rsX) & ~ex.mem_read → 2'b01 (that instruction will be in MEM).
  - else uses_X & match(mem,rsX) → 2'b10 (it will be in WB).
  - else → 2'b00.
  - Nearer producer has priority over the farther one.
- Load after one stall: the load sits in mem when the consumer is re-evaluated, so it yields 2'b10.
- On a bubble (stall, flush or id_valid=0), the registered selects load 2'b00.
- Register x0 is never forwarded and never causes a stall.
- Register-file write-then-read in the same cycle covers distance 3; no select is needed for it.
- Reset mid-operation: all in-flight metadata is discarded; the first instruction after reset sees no hazards.
- Simultaneous flush and stall: flush wins; stall output=0 and a bubble is inserted.

Optional Feature:
- FWD_STATS_EN defined:
  - stall_count increments every cycle stall=1.
  - fwd_count increments every cycle where (fwd_sel_a|fwd_sel_b)!=0.
  - Both counters saturate at all-ones and clear on reset.
- FWD_STATS_EN undefined: stall_count and fwd_count are tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package pipeline_pkg:
  - Select constants FWD_SEL_RF=2'b00, FWD_SEL_EXMEM=2'b01, FWD_SEL_MEMWB=2'b10.
  - Slot metadata struct typedef.
  - REG_ADDR_W default.
- One sub-module is natural: fwd_select, a combinational per-operand priority encoder instanced twice (operands A and B).

Test Plan:
- Back-to-back ALU dependency, add x5 then sub using x5 as rs1 → fwd_sel_a=01 in sub's EX cycle; stall never asserted.
- Distance-2 dependency, x6 written, one independent instruction, then read as rs2 → fwd_sel_b=10.
- Both producers write x7 at distances 1 and 2 → fwd_sel_a=01 (nearest wins).
- Load x8 followed by a consumer of x8 → stall=1 for exactly 1 cycle, EX bubble with selects 00, then consumer EX with select 10.
- Writes to x0 followed by a read of x0 → selects 00, no stall.
- Reset pulsed while a load-use hazard is pending → stall and selects immediately 0. With FWD_STATS_EN, after 3 load-use pairs stall_count=3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding-select codes, slot metadata, hazard helper.
package pipeline_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_SEL_RF    = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
  } slot_t;

  // A producer hits a source only if it really writes a non-x0 register with that index.
  function automatic logic reg_hit(input logic                      wr,
                                   input logic [DEF_REG_ADDR_W-1:0] rd,
                                   input logic [DEF_REG_ADDR_W-1:0] rs);
    return wr && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority encoder; the nearer producer wins.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  uses,
  input  logic [REG_ADDR_W-1:0] rs,
  input  slot_t                 ex_slot,
  input  logic                  mem_wr,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic [1:0]            sel_c
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = uses && reg_hit(ex_slot.valid && ex_slot.reg_write, ex_slot.rd, rs);
    mem_hit = uses && reg_hit(mem_wr, mem_rd, rs);
    sel_c   = FWD_SEL_RF;
    // A load in EX has no ALU result yet; it falls through to the MEM/WB path or stalls.
    if (ex_hit && !ex_slot.mem_read) begin
      sel_c = FWD_SEL_EXMEM;
    end else if (mem_hit) begin
      sel_c = FWD_SEL_MEMWB;
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// Hazard detection and ALU-operand forwarding control for the 5-stage pipeline.
// Optional statistics counters enabled by defining FWD_STATS_EN.
module forwarding_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      fwd_count
);

  // WB-distance hazards are covered by register-file write-through, so only
  // the EX slot and the write-relevant part of the MEM slot are kept.
  slot_t                 ex_q;
  logic                  mem_wr_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic [1:0]            sel_a_c;
  logic [1:0]            sel_b_c;
  logic                  load_use;
  logic                  bubble;

  always_comb begin
    load_use = ex_q.mem_read &&
               ((id_uses_rs1 && reg_hit(ex_q.valid && ex_q.reg_write, ex_q.rd, id_rs1)) ||
                (id_uses_rs2 && reg_hit(ex_q.valid && ex_q.reg_write, ex_q.rd, id_rs2)));
    stall    = id_valid && !flush && load_use;
    bubble   = stall || flush || !id_valid;
  end

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .uses    (id_uses_rs1),
    .rs      (id_rs1),
    .ex_slot (ex_q),
    .mem_wr  (mem_wr_q),
    .mem_rd  (mem_rd_q),
    .sel_c   (sel_a_c)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .uses    (id_uses_rs2),
    .rs      (id_rs2),
    .ex_slot (ex_q),
    .mem_wr  (mem_wr_q),
    .mem_rd  (mem_rd_q),
    .sel_c   (sel_b_c)
  );

  // Slot advance; selects are captured as the instruction enters EX.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_q      <= '0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= '0;
      fwd_sel_a <= FWD_SEL_RF;
      fwd_sel_b <= FWD_SEL_RF;
    end else begin
      mem_wr_q <= ex_q.valid && ex_q.reg_write;
      mem_rd_q <= ex_q.rd;
      if (bubble) begin
        ex_q      <= '0;
        fwd_sel_a <= FWD_SEL_RF;
        fwd_sel_b <= FWD_SEL_RF;
      end else begin
        ex_q.valid     <= 1'b1;
        ex_q.rd        <= id_rd;
        ex_q.reg_write <= id_reg_write;
        ex_q.mem_read  <= id_mem_read;
        fwd_sel_a      <= sel_a_c;
        fwd_sel_b      <= sel_b_c;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] fwd_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (((fwd_sel_a | fwd_sel_b) != 2'b00) && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign fwd_count   = fwd_cnt_q;
`else
  assign stall_count = '0;
  assign fwd_count   = '0;
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_forwarding_unit;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic [RW-1:0] id_rd;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          flush;
  logic [1:0]    fwd_sel_a;
  logic [1:0]    fwd_sel_b;
  logic          stall;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] fwd_count;

  always #5 clk = ~clk;

  forwarding_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall        (stall),
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
  );

  // Reference model: the last two instructions issued into EX, index = distance - 1.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } ins_t;

  ins_t     hist [2];
  bit [1:0] exp_a;
  bit [1:0] exp_b;
  int       exp_scnt;
  int       exp_fcnt;
  int       errors = 0;
  int       checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [1:0] model_sel(input bit uses, input bit [4:0] rs);
    if (!uses || rs == 5'd0) return 2'b00;
    for (int d = 0; d < 2; d++) begin
      if (hist[d].v && hist[d].wr && hist[d].rd == rs) begin
        if (d == 0 && hist[0].ld) continue;
        return (d == 0) ? 2'b01 : 2'b10;
      end
    end
    return 2'b00;
  endfunction

  function automatic bit model_stall();
    bit p;
    p = hist[0].v && hist[0].wr && hist[0].ld && hist[0].rd != 5'd0;
    return id_valid && !flush && p &&
           ((id_uses_rs1 && hist[0].rd == id_rs1) || (id_uses_rs2 && hist[0].rd == id_rs2));
  endfunction

  task automatic chk_counters(input string tag);
`ifdef FWD_STATS_EN
    chk({tag, "_stall_count"}, 32'(stall_count), 32'(exp_scnt));
    chk({tag, "_fwd_count"}, 32'(fwd_count), 32'(exp_fcnt));
`else
    chk({tag, "_stall_count"}, 32'(stall_count), 32'd0);
    chk({tag, "_fwd_count"}, 32'(fwd_count), 32'd0);
`endif
  endtask

  // One pipeline cycle: entered at posedge+1, returns at next posedge+1.
  task automatic step(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                      input bit u1, input bit u2, input bit [4:0] rd,
                      input bit wr, input bit ld, input bit fl, output logic st_dut);
    bit       st;
    bit       bub;
    bit [1:0] na;
    bit [1:0] nb;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_mem_read = ld; flush = fl;
    @(negedge clk);
    st     = model_stall();
    st_dut = stall;
    chk("stall", 32'(stall), 32'(st));
    na  = model_sel(u1, rs1);
    nb  = model_sel(u2, rs2);
    bub = st || fl || !v;
    if (st && exp_scnt < 65535) exp_scnt++;
    if ((exp_a | exp_b) != 2'b00 && exp_fcnt < 65535) exp_fcnt++;
    @(posedge clk);
    #1;
    hist[1] = hist[0];
    hist[0] = bub ? '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0} : '{v: 1'b1, rd: rd, wr: wr, ld: ld};
    exp_a   = bub ? 2'b00 : na;
    exp_b   = bub ? 2'b00 : nb;
    chk("sel_a", 32'(fwd_sel_a), 32'(exp_a));
    chk("sel_b", 32'(fwd_sel_b), 32'(exp_b));
    chk_counters("step");
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("rst_sel_b", 32'(fwd_sel_b), 32'd0);
    for (int i = 0; i < 2; i++) hist[i] = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
    exp_a = 2'b00; exp_b = 2'b00; exp_scnt = 0; exp_fcnt = 0;
    chk_counters("rst");
    id_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_sel_a", 32'(fwd_sel_a), 32'd0);
  endtask

  initial begin
    logic st;
    arst_n = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Back-to-back ALU dependency on x5
    step(1, 1, 2, 1, 1, 5, 1, 0, 0, st);
    step(1, 5, 3, 1, 1, 9, 1, 0, 0, st);
    chk("t1_stall", 32'(st), 32'd0);
    chk("t1_sel_a", 32'(fwd_sel_a), 32'd1);

    // Distance-2 dependency on x6 via rs2
    step(1, 1, 2, 1, 1, 6, 1, 0, 0, st);
    step(1, 1, 2, 1, 1, 10, 1, 0, 0, st);
    step(1, 3, 6, 1, 1, 11, 1, 0, 0, st);
    chk("t2_sel_b", 32'(fwd_sel_b), 32'd2);

    // Two producers of x7: nearest wins
    step(1, 1, 2, 1, 1, 7, 1, 0, 0, st);
    step(1, 1, 2, 1, 1, 7, 1, 0, 0, st);
    step(1, 7, 2, 1, 1, 12, 1, 0, 0, st);
    chk("t3_sel_a", 32'(fwd_sel_a), 32'd1);

    // Load-use on x8: one stall, bubble, then MEM/WB forward
    step(1, 1, 2, 1, 0, 8, 1, 1, 0, st);
    step(1, 8, 2, 1, 1, 13, 1, 0, 0, st);
    chk("t4_stall", 32'(st), 32'd1);
    chk("t4_bubble_a", 32'(fwd_sel_a), 32'd0);
    chk("t4_bubble_b", 32'(fwd_sel_b), 32'd0);
    step(1, 8, 2, 1, 1, 13, 1, 0, 0, st);
    chk("t4_stall_gone", 32'(st), 32'd0);
    chk("t4_sel_a", 32'(fwd_sel_a), 32'd2);

    // x0 writes never forward or stall
    step(1, 1, 2, 1, 1, 0, 1, 0, 0, st);
    step(1, 1, 2, 1, 1, 0, 1, 1, 0, st);
    step(1, 0, 0, 1, 1, 14, 1, 0, 0, st);
    chk("t5_stall", 32'(st), 32'd0);
    chk("t5_sel_a", 32'(fwd_sel_a), 32'd0);
    chk("t5_sel_b", 32'(fwd_sel_b), 32'd0);

    // Flush beats a pending load-use stall
    step(1, 1, 2, 1, 0, 15, 1, 1, 0, st);
    step(1, 15, 2, 1, 0, 16, 1, 0, 1, st);
    chk("t6_flush_stall", 32'(st), 32'd0);
    chk("t6_flush_sel_a", 32'(fwd_sel_a), 32'd0);

    // Reset while a load-use hazard is pending
    step(1, 1, 2, 1, 0, 8, 1, 1, 0, st);
    id_valid = 1'b1; id_rs1 = 5'd8; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
    id_rd = 5'd17; id_reg_write = 1'b1; id_mem_read = 1'b0; flush = 1'b0;
    #1;
    chk("t7_pre_stall", 32'(stall), 32'd1);
    do_reset();

    // Three load-use pairs
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 2, 1, 0, 9, 1, 1, 0, st);
      step(1, 9, 2, 1, 0, 18, 1, 0, 0, st);
      step(1, 9, 2, 1, 0, 18, 1, 0, 0, st);
    end
`ifdef FWD_STATS_EN
    chk("t8_stall_count", 32'(stall_count), 32'd3);
`else
    chk("t8_stall_count", 32'(stall_count), 32'd0);
`endif

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(99) < 85, 5'($urandom_range(3)), 5'($urandom_range(3)),
             1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(3)),
             $urandom_range(99) < 80, $urandom_range(99) < 35, $urandom_range(99) < 10, st);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
